fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage of the pipelined MIPS core: owns the PC, drives the instruction-memory address,
//  selects next PC (sequential/branch/jump/jr) and registers fetched word into the IF/ID latch.
//  Sits upstream of the combinational instruction ROM and the ID stage; redirects come from ID.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  EXC_VECTOR  32'h0000_0080  redirect target on misaligned fetch (FETCH_ALIGN_CHK_EN only)
//  NOP_INSTR   32'h0000_0000  word inserted into IF/ID on flush/bubble
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  stall          in   1   hazard unit: hold PC and IF/ID
//  flush          in   1   ID redirect/hazard: load bubble into IF/ID
//  pc_src         in   2   00 PC+4, 01 branch_target, 10 jump, 11 jr_target
//  branch_target  in   32  branch target computed in ID
//  jump_index     in   26  instr[25:0] of J/JAL in ID
//  jr_target      in   32  forwarded rs value for JR
//  imem_addr      out  32  current PC to instruction memory (Address)
//  imem_instr     in   32  instruction word from memory, combinational from imem_addr
//  ifid_pc        out  32  PC of instruction in IF/ID
//  ifid_pc_plus4  out  32  ifid_pc+4 (JAL link value, jump upper bits)
//  ifid_instr     out  32  latched instruction
//  ifid_valid     out  1   1 = real instruction, 0 = bubble
//  fetch_exc      out  1   misaligned-target event, 1-cycle pulse (macro only; else tied 0)
// BEHAVIOUR
//  - reset low: PC<=RESET_PC, ifid_pc/pc_plus4/instr<=0 (instr=NOP_INSTR), ifid_valid<=0,
//    fetch_exc<=0; immediate (async), including mid-operation; release is synchronous-safe.
//  - imem_addr == PC register always; no extra latency, word captured in IF/ID next edge.
//  - next PC (stall=0): pc_src 00 -> PC+4; 01 -> branch_target;
//    10 -> {ifid_pc_plus4[31:28], jump_index, 2'b00}; 11 -> jr_target.
//  - PC+4 is 32-bit modulo: 0xFFFF_FFFC wraps to 0x0000_0000, no flag.
//  - stall=1: PC and all ifid_* hold; pc_src ignored (ID instruction is itself held).
//  - flush=1, stall=0: PC updated per pc_src; ifid_instr<=NOP_INSTR, ifid_valid<=0,
//    ifid_pc/pc_plus4 <= current PC/PC+4.
//  - flush=1 & stall=1: PC holds; IF/ID takes bubble (flush wins on IF/ID).
//  - normal: ifid_pc<=PC, ifid_pc_plus4<=PC+4, ifid_instr<=imem_instr, ifid_valid<=1.
//  - redirect without flush is legal (delay-slot semantics): fetched slot word is kept.
//  - no FSM beyond PC/latch; one fetch per cycle, throughput 1 instr/clk when not stalled.
// CONFIGURATION
//  FETCH_ALIGN_CHK_EN defined: if selected next PC has [1:0]!=0 and stall=0, PC<=EXC_VECTOR,
//   fetch_exc pulses 1 for that cycle, IF/ID loads bubble (valid=0) regardless of flush.
//  Not defined: no check; next PC taken verbatim (low bits passed to memory, ignored there);
//   fetch_exc tied 0.
// TESTING
//  1 reset low mid-run -> imem_addr=0 at once, ifid_valid=0; release, 3 clks -> ifid_pc 0,4,8, valid=1.
//  2 ifid_pc_plus4=0x0000_000C, pc_src=10, jump_index=10 -> next imem_addr=0x0000_0028.
//  3 pc_src=11, jr_target=0x0000_000C, flush=1 -> imem_addr=0x0C, ifid_instr=0, valid=0.
//  4 stall=1 two cycles with pc_src=01 -> imem_addr and ifid_* unchanged; resume -> PC+4.
//  5 PC forced 0xFFFF_FFFC (via jr), pc_src=00 -> next imem_addr=0x0000_0000.
//  6 macro on: jr_target=0x0000_0006 -> imem_addr=0x80, fetch_exc=1 one cycle, valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- IF stage of the pipelined MIPS core.
//
// Owns the program counter, presents it to the combinational instruction
// memory, chooses the next PC (sequential / branch / jump / jr) and registers
// the fetched word into the IF/ID pipeline latch.
//
// Optional feature macro: FETCH_ALIGN_CHK_EN
//   Defined   : a selected next PC with [1:0] != 0 (while not stalled) is
//               replaced by EXC_VECTOR, fetch_exc pulses for one cycle and
//               IF/ID takes a bubble.
//   Undefined : no check, next PC taken verbatim, fetch_exc stays 0.
//
// Ports
//   clk            in   1   core clock, rising edge
//   reset          in   1   asynchronous active-low reset
//   stall          in   1   hold PC and IF/ID
//   flush          in   1   load bubble into IF/ID
//   pc_src         in   2   00 PC+4, 01 branch, 10 jump, 11 jr
//   branch_target  in   32  branch target from ID
//   jump_index     in   26  instr[25:0] of J/JAL in ID
//   jr_target      in   32  forwarded rs for JR
//   imem_addr      out  32  current PC
//   imem_instr     in   32  instruction word for imem_addr
//   ifid_pc        out  32  PC of instruction in IF/ID
//   ifid_pc_plus4  out  32  ifid_pc + 4
//   ifid_instr     out  32  latched instruction
//   ifid_valid     out  1   1 = real instruction, 0 = bubble
//   fetch_exc      out  1   misaligned-target pulse
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_exc
);

  logic [31:0] pc_q,            pc_d;
  logic [31:0] ifid_pc_q,       ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q,    ifid_instr_d;
  logic        ifid_valid_q,    ifid_valid_d;
  logic        fetch_exc_q,     fetch_exc_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        misalign_s;
  logic        bubble_s;

  // Sequential successor; 32-bit modulo add wraps 0xFFFF_FFFC to 0 silently.
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-PC selection from the redirect source chosen by ID.
  always_comb begin
    target_s = pc_plus4_s;
    case (pc_src)
      2'b00:   target_s = pc_plus4_s;
      2'b01:   target_s = branch_target;
      // Jump region comes from the instruction in ID, i.e. the latched PC+4.
      2'b10:   target_s = {ifid_pc_plus4_q[31:28], jump_index, 2'b00};
      2'b11:   target_s = jr_target;
      default: target_s = pc_plus4_s;
    endcase
  end

  // Misaligned-target detection, only meaningful when the PC actually moves.
  always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
    misalign_s = (target_s[1:0] != 2'b00) && !stall;
`else
    misalign_s = 1'b0;
`endif
  end

  // A trapped fetch discards IF/ID just like an explicit flush.
  assign bubble_s = flush | misalign_s;

  // Next-state computation for PC and IF/ID latch.
  always_comb begin
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_exc_d     = misalign_s;

    if (!stall) begin
      pc_d = misalign_s ? EXC_VECTOR : target_s;
    end else begin
      pc_d = pc_q;
    end

    // Flush wins over stall on the latch: a bubble is loaded even when held.
    if (bubble_s) begin
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4_s;
      ifid_instr_d    = NOP_INSTR;
      ifid_valid_d    = 1'b0;
    end else if (!stall) begin
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4_s;
      ifid_instr_d    = imem_instr;
      ifid_valid_d    = 1'b1;
    end else begin
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_valid_d    = ifid_valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      ifid_pc_q       <= 32'h0000_0000;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      fetch_exc_q     <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_exc_q     <= fetch_exc_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_exc     = fetch_exc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Each stimulus step pushes the state expected
// after the next rising edge; a monitor pops and compares on falling edges.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_exc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic        exc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction ROM stand-in: distinct, non-zero word per address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign imem_instr = rom(imem_addr);

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .fetch_exc     (fetch_exc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare DUT state against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".imem_addr"},     imem_addr,     e.addr);
      chk({e.tag, ".ifid_pc"},       ifid_pc,       e.pc);
      chk({e.tag, ".ifid_pc_plus4"}, ifid_pc_plus4, e.pc + 32'd4);
      chk({e.tag, ".ifid_instr"},    ifid_instr,    e.valid ? rom(e.pc) : 32'h0000_0000);
      chk({e.tag, ".ifid_valid"},    {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({e.tag, ".fetch_exc"},     {31'd0, fetch_exc},  {31'd0, e.exc});
    end
  end

  // Apply inputs for one cycle, record expectation for after the edge.
  task automatic step(input string tag, input logic st, input logic fl,
                      input logic [1:0] src, input logic [31:0] bt,
                      input logic [25:0] ji, input logic [31:0] jr,
                      input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic e_valid, input logic e_exc);
    exp_t e;
    stall = st; flush = fl; pc_src = src;
    branch_target = bt; jump_index = ji; jr_target = jr;
    @(posedge clk);
    e.addr = e_addr; e.pc = e_pc; e.valid = e_valid; e.exc = e_exc; e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic seq(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc);
    step(tag, 1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, e_addr, e_pc, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
    branch_target = 32'h0; jump_index = 26'h0; jr_target = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst0.imem_addr", imem_addr, 32'h0);
    chk("rst0.ifid_valid", {31'd0, ifid_valid}, 32'h0);
    reset = 1'b1;

    seq("run1", 32'h4, 32'h0);
    seq("run2", 32'h8, 32'h4);
    seq("run3", 32'hC, 32'h8);

    // Asynchronous reset mid-run, checked before any clock edge.
    #1 reset = 1'b0;
    #1;
    chk("arst.imem_addr",     imem_addr,     32'h0);
    chk("arst.ifid_valid",    {31'd0, ifid_valid}, 32'h0);
    chk("arst.ifid_pc",       ifid_pc,       32'h0);
    chk("arst.ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    chk("arst.ifid_instr",    ifid_instr,    32'h0);
    chk("arst.fetch_exc",     {31'd0, fetch_exc}, 32'h0);
    #1 reset = 1'b1;

    seq("rel1", 32'h4, 32'h0);
    seq("rel2", 32'h8, 32'h4);
    seq("rel3", 32'hC, 32'h8);

    // Jump: ifid_pc_plus4 = 0xC, index 10 -> 0x28.
    step("jump", 1'b0, 1'b0, 2'b10, 32'h0, 26'd10, 32'h0, 32'h28, 32'hC, 1'b1, 1'b0);
    seq("jump+1", 32'h2C, 32'h28);

    // JR with flush: redirect and bubble.
    step("jrfl", 1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 32'hC, 32'hC, 32'h2C, 1'b0, 1'b0);
    seq("jrfl+1", 32'h10, 32'hC);

    // Stall two cycles with a branch request: everything holds.
    step("stall1", 1'b1, 1'b0, 2'b01, 32'h100, 26'h0, 32'h0, 32'h10, 32'hC, 1'b1, 1'b0);
    step("stall2", 1'b1, 1'b0, 2'b01, 32'h100, 26'h0, 32'h0, 32'h10, 32'hC, 1'b1, 1'b0);
    seq("resume", 32'h14, 32'h10);

    // Flush and stall together: PC holds, IF/ID bubble.
    step("flst", 1'b1, 1'b1, 2'b01, 32'h100, 26'h0, 32'h0, 32'h14, 32'h14, 1'b0, 1'b0);
    seq("flst+1", 32'h18, 32'h14);

    // Branch taken without flush: delay slot kept.
    step("br", 1'b0, 1'b0, 2'b01, 32'h200, 26'h0, 32'h0, 32'h200, 32'h18, 1'b1, 1'b0);
    seq("br+1", 32'h204, 32'h200);

    // Wrap of PC+4 at the top of the address space.
    step("jrtop", 1'b0, 1'b0, 2'b11, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h204, 1'b1, 1'b0);
    seq("wrap", 32'h0, 32'hFFFF_FFFC);
    seq("wrap+1", 32'h4, 32'h0);

    // Misaligned JR target.
`ifdef FETCH_ALIGN_CHK_EN
    step("misal", 1'b0, 1'b0, 2'b11, 32'h0, 26'h0, 32'h6, 32'h80, 32'h4, 1'b0, 1'b1);
    seq("misal+1", 32'h84, 32'h80);
`else
    step("misal", 1'b0, 1'b0, 2'b11, 32'h0, 26'h0, 32'h6, 32'h6, 32'h4, 1'b1, 1'b0);
    seq("misal+1", 32'hA, 32'h6);
`endif

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
